// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - streams one VRAM frame in row-major order over valid/ready
// Optional feature macro: VRAM_SCANOUT_TEST_PATTERN_EN (adds enable_test_pattern, border test image)
module vram_scanout #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_W         = 16,
    localparam int L             = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int A             = $clog2(L)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              frame_start,
`ifdef VRAM_SCANOUT_TEST_PATTERN_EN
    input  logic              enable_test_pattern,
`endif
    output logic [A-1:0]      vram_rd_addr,
    input  logic [VRAM_W-1:0] vram_rd_data,
    output logic [VRAM_W-1:0] pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_last,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [A-1:0] LAST_ADDR = A'(L - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t state, state_nxt;

    // The address register doubles as the issue counter: the RAM samples it at the
    // end of the issue cycle, so its data is on vram_rd_data the following cycle.
    logic [A-1:0]      issue_cnt;
    logic              issue;
    logic              accept;
    logic              inflight;
    logic              inflight_last;
    logic              pop;
    logic [1:0]        count;
    logic [2:0]        occ;
    logic [VRAM_W-1:0] d0, d1;
    logic              l0, l1;
    logic [VRAM_W-1:0] push_data;

    assign vram_rd_addr = issue_cnt;
    assign pixel_valid  = (count != 2'd0);
    assign pixel_data   = d0;
    assign pixel_last   = pixel_valid & l0;
    assign pop          = pixel_valid & pixel_ready;
    assign accept       = (state == S_IDLE) & frame_start;
    assign occ          = {1'b0, count} + {2'b00, inflight};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_start) state_nxt = S_STREAM;
            S_STREAM: if (issue && issue_cnt == LAST_ADDR) state_nxt = S_DRAIN;
            S_DRAIN:  if (pop && pixel_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: read issue keeps buffered + in-flight pixels at two or fewer
    always_comb begin
        busy  = 1'b0;
        issue = 1'b0;
        case (state)
            S_STREAM: begin
                busy  = 1'b1;
                issue = ena && (occ < (3'd2 + {2'b00, pop}));
            end
            S_DRAIN:  busy = 1'b1;
            default:  ;
        endcase
    end

    // Issue counter: rewinds on acceptance, holds at the final address
    always_ff @(posedge clk) begin
        if (rst)                                  issue_cnt <= '0;
        else if (accept)                          issue_cnt <= '0;
        else if (issue && issue_cnt != LAST_ADDR) issue_cnt <= issue_cnt + 1'b1;
    end

    // In-flight read tracking; data lands in the buffer the cycle after issue
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issue_cnt == LAST_ADDR);
        end
    end

`ifdef VRAM_SCANOUT_TEST_PATTERN_EN
    localparam int XW = $clog2(DISPLAY_WIDTH + 1);
    localparam int YW = $clog2(DISPLAY_HEIGHT + 1);

    logic [XW-1:0] xcnt;
    logic [YW-1:0] ycnt;
    logic          tp_en;
    logic          border;
    logic          inflight_border;

    assign border = (xcnt == '0) || (xcnt == XW'(DISPLAY_WIDTH - 1)) ||
                    (ycnt == '0) || (ycnt == YW'(DISPLAY_HEIGHT - 1));

    // x/y shadow of the issue counter plus the per-frame pattern enable
    always_ff @(posedge clk) begin
        if (rst) begin
            xcnt            <= '0;
            ycnt            <= '0;
            tp_en           <= 1'b0;
            inflight_border <= 1'b0;
        end else begin
            inflight_border <= border;
            if (accept) begin
                xcnt  <= '0;
                ycnt  <= '0;
                tp_en <= enable_test_pattern;
            end else if (issue && issue_cnt != LAST_ADDR) begin
                if (xcnt == XW'(DISPLAY_WIDTH - 1)) begin
                    xcnt <= '0;
                    ycnt <= ycnt + 1'b1;
                end else begin
                    xcnt <= xcnt + 1'b1;
                end
            end
        end
    end

    assign push_data = tp_en ? (inflight_border ? {VRAM_W{1'b1}} : {VRAM_W{1'b0}})
                             : vram_rd_data;
`else
    assign push_data = vram_rd_data;
`endif

    // Two-entry pixel buffer; entry 0 is the head presented to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            d0    <= '0;
            d1    <= '0;
            l0    <= 1'b0;
            l1    <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        d0 <= push_data;
                        l0 <= inflight_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= inflight_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    d0    <= d1;
                    l0    <= l1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        d0 <= push_data;
                        l0 <= inflight_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= push_data;
                        l1 <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // End-of-frame pulse, one cycle after the last pixel is taken
    always_ff @(posedge clk) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= (state == S_DRAIN) && pop && pixel_last;
    end

endmodule
